// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, widths and the key-code map for the 4x4 hex
//               keypad scanner and its debounce/entry logic.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int KEYS    = ROWS * COLS;
  localparam int VALUE_W = 24;
  localparam int BUS_W   = 32;

  // Debounce state of the single-key recogniser.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } deb_state_t;

  // Classification of one complete 16-position keypad frame.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_kind_t;

  // Keypad legend, indexed by row*COLS + col.
  localparam logic [3:0] KEY_MAP [KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Translate a matrix position into the hex code printed on the key.
  function automatic logic [3:0] key_lookup(input logic [3:0] pos);
    return KEY_MAP[pos];
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_input_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Row-multiplexed scan of a 4x4 keypad. Synchronises the
//               column inputs, drives one row low per dwell period, gathers
//               a full 16-position frame and classifies it once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIVISOR = 32'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_n,
  output logic [ROWS-1:0]   row_n,
  output logic              frame_done,
  output frame_kind_t       frame_kind,
  output logic [3:0]        frame_code
);

  localparam logic [31:0] TERMINAL = 32'(SCAN_DIVISOR - 1);

  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_sync;
  logic [31:0]     prescale;
  logic [1:0]      row_idx;
  logic [1:0]      next_row;
  logic [KEYS-1:0] frame_acc;   // 1 = contact closed at that position
  logic [KEYS-1:0] frame_full;  // accumulator including the row sampled now
  logic            tick;
  logic [4:0]      hit_count;
  logic [3:0]      hit_pos;
  frame_kind_t     kind_now;

  assign tick     = (prescale == TERMINAL);
  assign next_row = row_idx + 2'd1;

  // Two-flop synchroniser for the asynchronous, active-low column lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Merge the row being sampled on this tick into the partial frame.
  always_comb begin
    frame_full = frame_acc;
    frame_full[{row_idx, 2'b00} +: COLS] = ~col_sync;
  end

  // Count closed contacts and remember where the (last) one sits.
  always_comb begin
    hit_count = 5'd0;
    hit_pos   = 4'd0;
    for (int i = 0; i < KEYS; i++) begin
      if (frame_full[i]) begin
        hit_count = hit_count + 5'd1;
        hit_pos   = 4'(i);
      end
    end
    if (hit_count == 5'd0) begin
      kind_now = NONE;
    end else if (hit_count == 5'd1) begin
      kind_now = SINGLE;
    end else begin
      kind_now = MULTI;
    end
  end

  // Prescaler, row rotation, frame accumulation and registered frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale   <= '0;
      row_idx    <= 2'd0;
      row_n      <= 4'b1110;
      frame_acc  <= '0;
      frame_done <= 1'b0;
      frame_kind <= NONE;
      frame_code <= 4'h0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        prescale <= '0;
        row_idx  <= next_row;
        row_n    <= ~(4'b0001 << next_row);
        if (row_idx == 2'd3) begin
          // Last row of the frame: publish the verdict and start afresh.
          frame_acc  <= '0;
          frame_done <= 1'b1;
          frame_kind <= kind_now;
          frame_code <= (kind_now == SINGLE) ? key_lookup(hit_pos) : 4'h0;
        end else begin
          frame_acc <= frame_full;
        end
      end else begin
        prescale <= prescale + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_input.sv
`default_nettype none
// ============================================================================
// Module      : keypad_input
// Description : Hex keypad entry block. Debounces scanned frames into single
//               key presses, shifts each accepted nybble into a 24-bit entry
//               value and exposes it, with a sticky new-key flag, to the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_input
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIVISOR   = 32'hFFFF,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              i_SYS_CLOCK,
  input  logic              i_RESET,
  input  logic [COLS-1:0]   i_COL,
  input  logic              i_WRITE_BUS,
  input  logic              i_ACK,
  input  logic              i_CLEAR_n,
  output logic [ROWS-1:0]   o_ROW,
  output logic [BUS_W-1:0]  o_BUS,
  output logic              o_KEY_VALID,
  output logic [3:0]        o_KEY_CODE
);

  localparam int            CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
  // With a single-frame debounce the first clean frame already qualifies.
  localparam bit            FIRST_HITS = (DEBOUNCE_SCANS == 1);

  logic               frame_done;
  frame_kind_t        frame_kind;
  logic [3:0]         frame_code;

  deb_state_t         state;
  logic [3:0]         cand;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept_now;
  logic [VALUE_W-1:0] entry_value;

  keypad_scanner #(
    .SCAN_DIVISOR (SCAN_DIVISOR)
  ) u_scanner (
    .clk        (i_SYS_CLOCK),
    .rst        (i_RESET),
    .col_n      (i_COL),
    .row_n      (o_ROW),
    .frame_done (frame_done),
    .frame_kind (frame_kind),
    .frame_code (frame_code)
  );

  assign cnt_inc = cnt + CNT_ONE;

  // A press is accepted on the frame that completes the run of matching frames.
  always_comb begin
    accept_now = 1'b0;
    if (frame_done && (frame_kind == SINGLE)) begin
      if ((state == IDLE) && FIRST_HITS) begin
        accept_now = 1'b1;
      end else if ((state == DEBOUNCE) && (frame_code == cand) &&
                   (cnt_inc == CNT_TARGET)) begin
        accept_now = 1'b1;
      end
    end
  end

  // Debounce state machine, advanced once per evaluated frame.
  always_ff @(posedge i_SYS_CLOCK) begin
    if (i_RESET) begin
      state <= IDLE;
      cand  <= 4'h0;
      cnt   <= '0;
    end else if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_kind == SINGLE) begin
            cand  <= frame_code;
            cnt   <= CNT_ONE;
            state <= FIRST_HITS ? PRESSED : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (frame_kind == SINGLE) begin
            if (frame_code == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_TARGET) begin
                state <= PRESSED;
              end
            end else begin
              // A different key showed up cleanly: restart on that one.
              cand <= frame_code;
              cnt  <= CNT_ONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        PRESSED: begin
          // Any contact keeps the key held; there is no auto-repeat.
          if (frame_kind == NONE) begin
            cnt   <= CNT_ONE;
            state <= FIRST_HITS ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (frame_kind == NONE) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_TARGET) begin
              state <= IDLE;
            end
          end else begin
            state <= PRESSED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry value and flags; clear outranks accept, accept outranks acknowledge.
  always_ff @(posedge i_SYS_CLOCK) begin
    if (i_RESET) begin
      entry_value <= '0;
      o_KEY_VALID <= 1'b0;
      o_KEY_CODE  <= 4'h0;
    end else if (!i_CLEAR_n) begin
      // The debounce state is untouched, so a held key is not taken twice.
      entry_value <= '0;
      o_KEY_VALID <= 1'b0;
    end else if (accept_now) begin
      entry_value <= {entry_value[VALUE_W-5:0], frame_code};
      o_KEY_CODE  <= frame_code;
      o_KEY_VALID <= 1'b1;
    end else if (i_ACK) begin
      o_KEY_VALID <= 1'b0;
    end
  end

  assign o_BUS = i_WRITE_BUS ? {{(BUS_W - VALUE_W){1'b0}}, entry_value} : '0;

endmodule
`default_nettype wire

// File: tb/tb_keypad_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_input
// Description : Self-checking bench for keypad_input. A behavioural keypad
//               drives the columns from the row strobes; a frame-level model
//               of press/release qualification predicts the CPU-visible state.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_input;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic        write_bus = 1'b1;
  logic        ack = 1'b0;
  logic        clear_n = 1'b1;
  logic [3:0]  row;
  logic [31:0] bus;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] keys = 16'h0;   // bit r*4+c set = that key is held down
  logic [3:0]  key_tab [16];

  int errors = 0;
  int checks = 0;

  // Model state
  logic [23:0] m_value;
  logic        m_valid;
  logic [3:0]  m_code;
  bit          armed;
  logic [3:0]  run_key;
  int          run_len;
  int          none_len;

  keypad_input #(
    .SCAN_DIVISOR   (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .i_SYS_CLOCK (clk),
    .i_RESET     (rst),
    .i_COL       (col),
    .i_WRITE_BUS (write_bus),
    .i_ACK       (ack),
    .i_CLEAR_n   (clear_n),
    .o_ROW       (row),
    .o_BUS       (bus),
    .o_KEY_VALID (key_valid),
    .o_KEY_CODE  (key_code)
  );

  always #5 clk = ~clk;

  // Passive keypad: a held key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~keys[r*4 +: 4];
    end
  end

  function automatic logic [15:0] key_of(input logic [3:0] code);
    logic [15:0] m;
    m = 16'h0;
    for (int i = 0; i < 16; i++) if (key_tab[i] == code) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] code_of(input logic [15:0] k);
    logic [3:0] c;
    c = 4'h0;
    for (int i = 0; i < 16; i++) if (k[i]) c = key_tab[i];
    return c;
  endfunction

  function automatic logic [31:0] exp_bus();
    return write_bus ? {8'h00, m_value} : 32'h0;
  endfunction

  task automatic model_reset();
    m_value = 24'h0; m_valid = 1'b0; m_code = 4'h0;
    armed = 1'b1; run_key = 4'h0; run_len = 0; none_len = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; ack = 1'b0; clear_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // One full frame with keys k held; optional ack/clear at clock offset 0..15
  // (offset 15 lands on the clock that publishes this frame's accept).
  task automatic do_frame(input logic [15:0] k, input int ack_at, input int clr_at);
    int n;
    bit acc;
    logic [3:0] kc;
    keys = k;
    for (int i = 0; i < 16; i++) begin
      ack = (i == ack_at);
      clear_n = !(i == clr_at);
      @(negedge clk);
    end
    ack = 1'b0;
    clear_n = 1'b1;
    n = $countones(k);
    kc = code_of(k);
    acc = 1'b0;
    if (armed) begin
      if (n == 1) begin
        if (run_len > 0 && kc == run_key) run_len++;
        else begin run_key = kc; run_len = 1; end
        if (run_len == int'(DEB)) begin acc = 1'b1; armed = 1'b0; none_len = 0; end
      end else begin
        run_len = 0;
      end
    end else begin
      if (n == 0) begin
        none_len++;
        if (none_len == int'(DEB)) begin armed = 1'b1; run_len = 0; end
      end else begin
        none_len = 0;
      end
    end
    for (int t = 0; t < 16; t++) begin
      if (t == clr_at) begin m_value = 24'h0; m_valid = 1'b0; end
      else if (acc && t == 15) begin m_value = {m_value[19:0], kc}; m_code = kc; m_valid = 1'b1; end
      else if (t == ack_at) m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst = 1'b1; write_bus = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", row); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h want 0", key_code); end
    checks++; if (bus !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", bus); end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      checks++; if (row !== exp_row) begin errors++; $display("FAIL row_cycle clk%0d: got %b want %b", i, row, exp_row); end
    end
  endtask

  task automatic test_hold_five();
    apply_reset();
    write_bus = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      do_frame(key_of(4'h5), (f == 3) ? 0 : -1, -1);
      checks++; if (key_valid !== m_valid) begin errors++; $display("FAIL hold5_valid f%0d: got %b want %b", f, key_valid, m_valid); end
      checks++; if (bus !== exp_bus()) begin errors++; $display("FAIL hold5_bus f%0d: got %h want %h", f, bus, exp_bus()); end
      if (f == 2) begin
        checks++; if (key_code !== 4'h5 || bus !== 32'h00000005 || key_valid !== 1'b1) begin
          errors++; $display("FAIL hold5_accept: code %h bus %h valid %b want 5/00000005/1", key_code, bus, key_valid); end
      end
    end
    repeat (3) do_frame(16'h0, -1, -1);
  endtask

  task automatic test_sequence();
    logic [3:0] seq [7];
    seq = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6};
    write_bus = 1'b1;
    foreach (seq[j]) begin
      repeat (3) do_frame(key_of(seq[j]), -1, -1);
      checks++; if (key_code !== seq[j] || key_valid !== 1'b1) begin
        errors++; $display("FAIL seq_code k%0d: code %h valid %b want %h/1", j, key_code, key_valid, seq[j]); end
      repeat (3) do_frame(16'h0, -1, -1);
    end
    checks++; if (bus !== 32'h0023A456) begin errors++; $display("FAIL seq_bus: got %h want 0023a456", bus); end
    checks++; if (bus !== exp_bus()) begin errors++; $display("FAIL seq_bus_model: got %h want %h", bus, exp_bus()); end
    write_bus = 1'b0;
    #1;
    checks++; if (bus !== 32'h0) begin errors++; $display("FAIL seq_bus_off: got %h want 0", bus); end
    write_bus = 1'b1;
  endtask

  task automatic test_bounce();
    apply_reset();
    do_frame(key_of(4'h7), -1, -1);
    repeat (3) do_frame(16'h0, -1, -1);
    checks++; if (key_valid !== 1'b0 || key_valid !== m_valid) begin errors++; $display("FAIL bounce_single: valid %b want 0", key_valid); end
    do_frame(key_of(4'h7), -1, -1);
    do_frame(key_of(4'h8), -1, -1);
    repeat (3) do_frame(16'h0, -1, -1);
    checks++; if (key_valid !== 1'b0 || key_valid !== m_valid) begin errors++; $display("FAIL bounce_switch: valid %b want 0", key_valid); end
    repeat (4) do_frame(key_of(4'h1) | key_of(4'h9), -1, -1);
    checks++; if (key_valid !== 1'b0 || key_valid !== m_valid) begin errors++; $display("FAIL bounce_ghost: valid %b want 0", key_valid); end
    repeat (3) do_frame(16'h0, -1, -1);
    checks++; if (bus !== 32'h0) begin errors++; $display("FAIL bounce_bus: got %h want 0", bus); end
  endtask

  task automatic test_ack();
    apply_reset();
    do_frame(key_of(4'hC), -1, -1);
    do_frame(key_of(4'hC), 15, -1);
    checks++; if (key_valid !== 1'b1 || key_valid !== m_valid) begin errors++; $display("FAIL ack_coincident: valid %b want 1", key_valid); end
    do_frame(key_of(4'hC), 0, -1);
    checks++; if (key_valid !== 1'b0 || key_valid !== m_valid) begin errors++; $display("FAIL ack_after: valid %b want 0", key_valid); end
    checks++; if (key_code !== 4'hC) begin errors++; $display("FAIL ack_code: got %h want c", key_code); end
    repeat (2) do_frame(16'h0, -1, -1);
  endtask

  task automatic test_clear();
    apply_reset();
    repeat (2) do_frame(key_of(4'h3), -1, -1);
    do_frame(key_of(4'h3), -1, 5);
    checks++; if (bus !== 32'h0 || key_valid !== 1'b0) begin errors++; $display("FAIL clear_now: bus %h valid %b want 0/0", bus, key_valid); end
    repeat (2) do_frame(key_of(4'h3), -1, -1);
    checks++; if (key_valid !== m_valid || bus !== exp_bus()) begin errors++; $display("FAIL clear_held: valid %b bus %h want %b/%h", key_valid, bus, m_valid, exp_bus()); end
    repeat (2) do_frame(16'h0, -1, -1);
    repeat (2) do_frame(key_of(4'h3), -1, -1);
    checks++; if (bus !== 32'h3 || key_valid !== 1'b1) begin errors++; $display("FAIL clear_repress: bus %h valid %b want 3/1", bus, key_valid); end
    repeat (2) do_frame(16'h0, -1, -1);
    do_frame(key_of(4'h9), -1, -1);
    do_frame(key_of(4'h9), -1, 15);
    do_frame(key_of(4'h9), -1, -1);
    checks++; if (key_valid !== 1'b0 || bus !== exp_bus() || key_valid !== m_valid) begin
      errors++; $display("FAIL clear_drop: valid %b bus %h want 0/%h", key_valid, bus, exp_bus()); end
    repeat (2) do_frame(16'h0, -1, -1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_frame(key_of(4'h4), -1, -1);
    do_frame(key_of(4'h4), -1, -1);
    do_frame(16'h0, -1, -1);
    do_frame(16'h0, -1, -1);
    do_frame(key_of(4'hB), -1, -1);
    keys = key_of(4'hB);
    apply_reset();
    checks++; if (key_valid !== 1'b0 || bus !== 32'h0 || row !== 4'b1110) begin
      errors++; $display("FAIL rstmid_state: valid %b bus %h row %b want 0/0/1110", key_valid, bus, row); end
    do_frame(key_of(4'hB), -1, -1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early: valid %b want 0", key_valid); end
    do_frame(key_of(4'hB), -1, -1);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'hB || bus !== 32'h0000000B) begin
      errors++; $display("FAIL rstmid_accept: valid %b code %h bus %h want 1/b/0000000b", key_valid, key_code, bus); end
    repeat (2) do_frame(16'h0, -1, -1);
  endtask

  task automatic test_random();
    logic [15:0] pat;
    int hold, sel, a_at, c_at, p, q;
    logic [15:0] last_single;
    last_single = key_of(4'h0);
    for (int blk = 0; blk < 45; blk++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) pat = 16'h0;
      else if (sel < 9) begin
        if ($urandom_range(0, 2) != 0) pat = last_single;
        else begin p = $urandom_range(0, 15); pat = 16'h0; pat[p] = 1'b1; last_single = pat; end
      end else begin
        p = $urandom_range(0, 15); q = (p + $urandom_range(1, 15)) % 16;
        pat = 16'h0; pat[p] = 1'b1; pat[q] = 1'b1;
      end
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        a_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
        c_at = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 15) : -1;
        write_bus = $urandom_range(0, 1) != 0;
        do_frame(pat, a_at, c_at);
        checks++; if (key_valid !== m_valid) begin errors++; $display("FAIL rand_valid b%0d: got %b want %b", blk, key_valid, m_valid); end
        checks++; if (key_code !== m_code) begin errors++; $display("FAIL rand_code b%0d: got %h want %h", blk, key_code, m_code); end
        checks++; if (bus !== exp_bus()) begin errors++; $display("FAIL rand_bus b%0d: got %h want %h", blk, bus, exp_bus()); end
      end
    end
  endtask

  initial begin
    key_tab = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    model_reset();
    test_reset();
    test_hold_five();
    test_sequence();
    test_bounce();
    test_ack();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
